// File: rtl/byte_queue_if.sv
// Byte-queue handshake and pop bus.
// The master side is the deserializer plus consumer; the slave side is the queue.
interface byte_queue_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    // Producer (deserializer) handshake
    logic [7:0]       data_in;
    logic             data_ready;
    logic             ack_out;

    // Consumer pop side
    logic             dequeue_in;
    logic [7:0]       data_out;
    logic             data_valid;

    // Occupancy status
    logic [CNT_W-1:0] len_out;
    logic             queue_full;
    logic             queue_empty;

    modport master (
        output data_in,
        output data_ready,
        output dequeue_in,
        input  ack_out,
        input  data_out,
        input  data_valid,
        input  len_out,
        input  queue_full,
        input  queue_empty
    );

    modport slave (
        input  data_in,
        input  data_ready,
        input  dequeue_in,
        output ack_out,
        output data_out,
        output data_valid,
        output len_out,
        output queue_full,
        output queue_empty
    );
endinterface

// File: rtl/byte_queue.sv
// Byte FIFO behind the serial-to-byte deserializer.
// It captures each completed byte through a data_ready/ack handshake and
// withholds ack while full, which back-pressures the deserializer.
// A consumer pops one byte per dequeue strobe; the popped byte is registered.
module byte_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clock_100,
    input  logic         reset,
    byte_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ack;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_len;
    logic [7:0]       r_mem [DEPTH];
    logic [7:0]       r_data_out;
    logic             r_data_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    // Status flags are decoded from the registered occupancy count.
    assign w_full  = (r_len == CNT_W'(DEPTH));
    assign w_empty = (r_len == '0);

    // A write happens only from IDLE with room left. A full queue leaves the
    // byte pending on data_ready, so nothing is dropped.
    assign w_wr = (r_state == IDLE) && bus.data_ready && !w_full;

    // A pop on an empty queue is ignored and not remembered. Because of this,
    // a same-cycle write into an empty queue is never bypassed to data_out.
    assign w_rd = bus.dequeue_in && !w_empty;

    // Input handshake FSM with a registered one-cycle acknowledge.
    always_ff @(posedge clock_100) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_ack   <= 1'b0;
                    end
                end
                ACK: begin
                    r_state <= WAIT_LOW;
                    r_ack   <= 1'b0;
                end
                WAIT_LOW: begin
                    // Holding here until data_ready drops ensures one write per byte.
                    r_ack <= 1'b0;
                    if (!bus.data_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // The write pointer advances on each accepted byte and wraps naturally.
    always_ff @(posedge clock_100) begin
        if (!reset) begin
            r_wptr <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + PTR_W'(1);
        end
    end

    // Storage array. It has no reset because its contents are don't-care
    // until written.
    always_ff @(posedge clock_100) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.data_in;
        end
    end

    // Pop path: registered data_out, a one-cycle data_valid pulse and the
    // read pointer.
    always_ff @(posedge clock_100) begin
        if (!reset) begin
            r_rptr       <= '0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd;
            if (w_rd) begin
                r_data_out <= r_mem[r_rptr];
                r_rptr     <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Occupancy count. A simultaneous write and pop leave it unchanged.
    always_ff @(posedge clock_100) begin
        if (!reset) begin
            r_len <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_len <= r_len + CNT_W'(1);
                2'b01:   r_len <= r_len - CNT_W'(1);
                default: r_len <= r_len;
            endcase
        end
    end

    assign bus.ack_out     = r_ack;
    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.len_out     = r_len;
    assign bus.queue_full  = w_full;
    assign bus.queue_empty = w_empty;

    // Structural invariants of the queue.
    a_len_bound: assert property (@(posedge clock_100) disable iff (!reset)
        r_len <= CNT_W'(DEPTH));
    a_ack_state: assert property (@(posedge clock_100) disable iff (!reset)
        r_ack |-> (r_state == ACK));
    a_ptr_len: assert property (@(posedge clock_100) disable iff (!reset)
        (r_wptr - r_rptr) == PTR_W'(r_len));

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue.
// A scoreboard queue of expected bytes is filled when a byte is offered and
// drained by a monitor whenever data_valid pulses.
module tb_byte_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clock_100 = 1'b0;
    logic reset     = 1'b0;

    always #5 clock_100 = ~clock_100;

    byte_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bq ();

    byte_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_100 (clock_100),
        .reset     (reset),
        .bus       (bq)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];
    int         ack_cnt  = 0;
    int         dv_cnt   = 0;
    logic       prev_ack = 1'b0;
    logic       track_len = 1'b0;
    int         max_len  = 0;
    logic       prod_done = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Samples DUT outputs mid-cycle, after the monitor has run.
    task automatic at_neg();
        @(negedge clock_100);
        #1;
    endtask

    // Advances to the next drive point, just after a rising edge.
    task automatic tick();
        @(posedge clock_100);
        #1;
    endtask

    // Waits a bounded number of cycles for ack. It then behaves like the
    // deserializer: data_ready drops one cycle after ack is seen.
    task automatic wait_ack_release(input int max_cycles);
        int n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (n < max_cycles && !got) begin
            at_neg();
            if (bq.ack_out) got = 1'b1;
            n++;
        end
        check("ack_seen", 32'(got), 32'd1);
        tick();
        bq.data_ready = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bq.data_in    = b;
        bq.data_ready = 1'b1;
        sb.push_back(b);
        wait_ack_release(20);
    endtask

    task automatic pop_once();
        bq.dequeue_in = 1'b1;
        tick();
        bq.dequeue_in = 1'b0;
    endtask

    // Monitor: scoreboard compare on every data_valid, ack pulse width, peak occupancy.
    always @(negedge clock_100) begin
        if (reset) begin
            if (bq.ack_out) begin
                ack_cnt++;
                check("ack_width", 32'(prev_ack), 32'd0);
            end
            if (bq.data_valid) begin
                dv_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("data_out_order", 32'(bq.data_out), 32'(mon_exp));
                end
            end
            if (track_len && int'(bq.len_out) > max_len) max_len = int'(bq.len_out);
        end
        prev_ack = bq.ack_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int d0;
        int n;

        // Reset held with a byte pending: nothing may be acknowledged or stored.
        bq.data_in    = 8'h5A;
        bq.data_ready = 1'b1;
        bq.dequeue_in = 1'b0;
        reset         = 1'b0;
        repeat (3) begin
            at_neg();
            check("rst_ack",   32'(bq.ack_out),     32'd0);
            check("rst_len",   32'(bq.len_out),     32'd0);
            check("rst_empty", 32'(bq.queue_empty), 32'd1);
            check("rst_full",  32'(bq.queue_full),  32'd0);
            check("rst_dout",  32'(bq.data_out),    32'h00);
            check("rst_dv",    32'(bq.data_valid),  32'd0);
        end
        tick();
        reset = 1'b1;
        sb.push_back(8'h5A);
        wait_ack_release(2);
        check("rst_accept_len", 32'(bq.len_out), 32'd1);
        pop_once();
        check("rst_pop_len", 32'(bq.len_out), 32'd0);

        // Single byte: one ack pulse, len 0->1->0, one valid, data_out held.
        a0 = ack_cnt;
        send_byte(8'hA5);
        check("single_len1", 32'(bq.len_out), 32'd1);
        check("single_acks", 32'(ack_cnt - a0), 32'd1);
        tick();
        tick();
        d0 = dv_cnt;
        pop_once();
        check("single_dv",   32'(bq.data_valid), 32'd1);
        check("single_dout", 32'(bq.data_out),   32'hA5);
        check("single_len0", 32'(bq.len_out),    32'd0);
        tick();
        check("single_dv_low",  32'(bq.data_valid),  32'd0);
        check("single_hold",    32'(bq.data_out),    32'hA5);
        check("single_empty",   32'(bq.queue_empty), 32'd1);
        check("single_dv_once", 32'(dv_cnt - d0),    32'd1);

        // Fill to DEPTH, then a ninth byte must be held off until a pop frees room.
        a0 = ack_cnt;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("fill_len",  32'(bq.len_out),    32'd8);
        check("fill_full", 32'(bq.queue_full), 32'd1);
        check("fill_acks", 32'(ack_cnt - a0),  32'd8);
        bq.data_in    = 8'h09;
        bq.data_ready = 1'b1;
        sb.push_back(8'h09);
        repeat (5) tick();
        check("full_no_ack",     32'(ack_cnt - a0), 32'd8);
        check("full_ack_low",    32'(bq.ack_out),   32'd0);
        check("full_len_stable", 32'(bq.len_out),   32'd8);
        pop_once();
        check("bp_pop_dout", 32'(bq.data_out), 32'h01);
        wait_ack_release(5);
        check("bp_len_refill",  32'(bq.len_out),    32'd8);
        check("bp_full_refill", 32'(bq.queue_full), 32'd1);

        // Drain with 9 back-to-back pops; the last finds the queue empty.
        d0 = dv_cnt;
        bq.dequeue_in = 1'b1;
        repeat (9) tick();
        bq.dequeue_in = 1'b0;
        check("drain_last_dv", 32'(bq.data_valid), 32'd0);
        at_neg();
        check("drain_valids", 32'(dv_cnt - d0),     32'd8);
        check("drain_len",    32'(bq.len_out),      32'd0);
        check("drain_empty",  32'(bq.queue_empty),  32'd1);
        check("drain_sb",     32'(sb.size()),       32'd0);
        tick();

        // Stream 0x10..0x23 while popping every cycle; the pointers wrap twice.
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        check("stream_len3", 32'(bq.len_out), 32'd3);
        d0        = dv_cnt - 0;
        max_len   = 0;
        track_len = 1'b1;
        prod_done = 1'b0;
        fork
            begin
                for (int b = 8'h13; b <= 8'h23; b++) send_byte(8'(b));
                prod_done = 1'b1;
            end
            begin
                bq.dequeue_in = 1'b1;
                n = 0;
                while (!(prod_done && sb.size() == 0) && n < 2000) begin
                    tick();
                    n++;
                end
                bq.dequeue_in = 1'b0;
                check("stream_timeout", 32'(n < 2000), 32'd1);
            end
        join
        track_len = 1'b0;
        tick();
        check("stream_maxlen", 32'(max_len <= 3), 32'd1);
        check("stream_valids", 32'(dv_cnt - d0),  32'd20);
        check("stream_len0",   32'(bq.len_out),   32'd0);

        // Reset while holding 5 bytes with the FSM in WAIT_LOW.
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
        check("mid_len5", 32'(bq.len_out), 32'd5);
        bq.data_in    = 8'h66;
        bq.data_ready = 1'b1;
        n = 0;
        while (!bq.ack_out && n < 10) begin
            at_neg();
            n++;
        end
        check("mid_ack_seen", 32'(bq.ack_out), 32'd1);
        tick();
        reset         = 1'b0;
        bq.data_ready = 1'b0;
        sb.delete();
        tick();
        reset = 1'b1;
        check("mid_rst_len",   32'(bq.len_out),     32'd0);
        check("mid_rst_ack",   32'(bq.ack_out),     32'd0);
        check("mid_rst_empty", 32'(bq.queue_empty), 32'd1);
        check("mid_rst_dout",  32'(bq.data_out),    32'h00);
        send_byte(8'h77);
        check("mid_post_len", 32'(bq.len_out), 32'd1);
        pop_once();
        check("mid_post_dout", 32'(bq.data_out), 32'h77);
        pop_once();
        check("empty_pop_dv",  32'(bq.data_valid), 32'd0);
        check("empty_pop_len", 32'(bq.len_out),    32'd0);
        tick();
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
